// File: rtl/count_slice_pkg.sv
// Shared definitions for the sliced count link receiver: default geometry and FSM states.
package count_slice_pkg;

    localparam int unsigned DEF_SLICE_W = 2;
    localparam int unsigned DEF_WORD_W  = 16;
    localparam int unsigned BEATS       = DEF_WORD_W / DEF_SLICE_W;
    localparam int unsigned BCNT_W      = $clog2(BEATS);

    typedef enum logic [1:0] {
        COLLECT,
        LAST,
        PEND
    } rx_state_t;

    function automatic int unsigned beats_of(input int unsigned word_w,
                                             input int unsigned slice_w);
        return word_w / slice_w;
    endfunction

endpackage

// File: rtl/count_slice_rx.sv
// Reassembles SLICE_W-bit beats into a WORD_W-bit count word and presents it on a
// valid/ready port, flagging and counting framing errors.
module count_slice_rx
    import count_slice_pkg::*;
#(
    parameter int unsigned SLICE_W   = DEF_SLICE_W,
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned ERR_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SLICE_W-1:0] in_slice,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_word,
    output logic               err_frame,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int unsigned NBeats = beats_of(WORD_W, SLICE_W);
    localparam int unsigned CntW   = (NBeats > 1) ? $clog2(NBeats) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(NBeats - 1);

    if ((WORD_W % SLICE_W) != 0 || WORD_W <= SLICE_W) begin : g_bad_geometry
        $error("WORD_W must be a multiple of SLICE_W and larger than it");
    end

    rx_state_t          state_q, state_d;
    logic [CntW-1:0]    bcnt_q, bcnt_d;
    logic [WORD_W-1:0]  sh_q, sh_d, sh_next;
    logic [WORD_W-1:0]  out_word_q, out_word_d;
    logic               out_valid_q, out_valid_d;
    logic               err_frame_q, err_frame_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               in_ready_q, in_ready_d;

    logic accept, take, at_last, good_end, frame_err, can_load;

    assign accept    = in_valid && in_ready_q;
    assign take      = out_valid_q && out_ready;
    assign at_last   = (state_q == LAST);
    assign good_end  = accept && at_last && in_last;
    assign frame_err = accept && (at_last != in_last);
    // The output register can take a fresh word if it is empty or being drained now.
    assign can_load  = !out_valid_q || out_ready;

    always_comb begin
        if (MSB_FIRST) begin
            sh_next = {sh_q[WORD_W-SLICE_W-1:0], in_slice};
        end else begin
            sh_next = {in_slice, sh_q[WORD_W-1:SLICE_W]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: begin
                if (accept && !in_last && bcnt_q == LastBeat - 1'b1) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                if (accept) begin
                    state_d = (good_end && !can_load) ? PEND : COLLECT;
                end
            end
            PEND: begin
                if (take) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        bcnt_d      = bcnt_q;
        sh_d        = sh_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        err_frame_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        in_ready_d  = (state_d != PEND);

        if (take) begin
            out_valid_d = 1'b0;
        end
        if (state_q == PEND && take) begin
            out_word_d  = sh_q;
            out_valid_d = 1'b1;
        end

        if (accept) begin
            if (frame_err) begin
                bcnt_d      = '0;
                sh_d        = '0;
                err_frame_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end else if (good_end) begin
                bcnt_d = '0;
                sh_d   = sh_next;
                if (can_load) begin
                    out_word_d  = sh_next;
                    out_valid_d = 1'b1;
                end
            end else begin
                bcnt_d = bcnt_q + 1'b1;
                sh_d   = sh_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt_q      <= '0;
            sh_q        <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            err_frame_q <= 1'b0;
            err_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            bcnt_q      <= bcnt_d;
            sh_q        <= sh_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            err_frame_q <= err_frame_d;
            err_cnt_q   <= err_cnt_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign err_frame = err_frame_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_count_slice_rx.sv
// Bench for count_slice_rx: word-queue reference model checked every cycle, plus
// directed frames with literal expectations.
module tb_count_slice_rx;

    localparam int BEATS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, err_frame;
    logic [1:0]  in_slice;
    logic [15:0] out_word;
    logic [7:0]  err_cnt;

    logic        l_in_valid, l_in_ready, l_in_last, l_out_valid, l_out_ready, l_err_frame;
    logic [1:0]  l_in_slice;
    logic [15:0] l_out_word;
    logic [7:0]  l_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    count_slice_rx #(.SLICE_W(2), .WORD_W(16), .MSB_FIRST(1'b1), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_slice(in_slice), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .err_frame(err_frame),
        .err_cnt(err_cnt)
    );

    count_slice_rx #(.SLICE_W(2), .WORD_W(16), .MSB_FIRST(1'b0), .ERR_W(8)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .in_slice(l_in_slice), .in_last(l_in_last), .out_valid(l_out_valid),
        .out_ready(l_out_ready), .out_word(l_out_word), .err_frame(l_err_frame),
        .err_cnt(l_err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: words held in the output register plus pending slot (max 2),
    // and the beats of the word in progress.
    logic [15:0] m_q[$];
    logic [1:0]  m_beats[$];
    bit          m_live = 0;
    bit          m_err_pulse = 0;
    int          m_err_cnt = 0;
    bit          m_acc;
    logic [15:0] m_w;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_q.delete();
            m_beats.delete();
            m_live      = 0;
            m_err_pulse = 0;
            m_err_cnt   = 0;
        end else begin
            m_acc       = in_valid && m_live && (m_q.size() < 2);
            m_err_pulse = 0;
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (m_acc) begin
                if (in_last != (m_beats.size() == BEATS - 1)) begin
                    m_beats.delete();
                    m_err_pulse = 1;
                    if (m_err_cnt < 255) m_err_cnt++;
                end else begin
                    m_beats.push_back(in_slice);
                    if (m_beats.size() == BEATS) begin
                        m_w = '0;
                        for (int i = 0; i < BEATS; i++)
                            m_w = m_w | (16'(m_beats[i]) << (2 * (BEATS - 1 - i)));
                        m_q.push_back(m_w);
                        m_beats.delete();
                    end
                end
            end
            m_live = 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_word", 32'(out_word), 0);
            chk("rst_err_frame", 32'(err_frame), 0);
            chk("rst_err_cnt", 32'(err_cnt), 0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(m_live && (m_q.size() < 2)));
            chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) chk("out_word", 32'(out_word), 32'(m_q[0]));
            chk("err_frame", 32'(err_frame), 32'(m_err_pulse));
            chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
        end
    end

    logic [15:0] hs_w[$];
    int          hs_c[$];
    always @(posedge clk) begin
        if (rst && out_valid && out_ready) begin
            hs_w.push_back(out_word);
            hs_c.push_back(cyc);
        end
    end

    // Drives one beat and returns on the clock edge that accepts it.
    task automatic send(input logic [1:0] s, input logic l);
        int t = 0;
        @(negedge clk);
        #1;
        while (!in_ready && t < 50) begin
            in_valid = 1'b0;
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 50) chk("send_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_slice = s;
        in_last  = l;
        @(posedge clk);
    endtask

    // Beats are taken MSB-first from w; in_last is set on beat number last_at (0 = never).
    task automatic send_frame(input logic [15:0] w, input int n, input int last_at);
        for (int i = 0; i < n; i++) send(w[15-2*i -: 2], (i + 1) == last_at);
    endtask

    task automatic idle();
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_slice = '0; in_last = 1'b0; out_ready = 1'b1;
        l_in_valid = 1'b0; l_in_slice = '0; l_in_last = 1'b0; l_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_err_cnt", 32'(err_cnt), 0);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 1);

        // 1: single frame, consumer always ready
        send_frame(16'h1B1B, 8, 8);
        @(negedge clk);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_word", 32'(out_word), 32'h1B1B);
        chk("t1_err_frame", 32'(err_frame), 0);
        idle();

        // 2: backpressure, second word parks in the pending slot
        @(negedge clk);
        #1 out_ready = 1'b0;
        send_frame(16'h1B1B, 8, 8);
        send_frame(16'hFFFF, 8, 8);
        @(negedge clk);
        chk("t2_in_ready_blocked", 32'(in_ready), 0);
        chk("t2_out_word_held", 32'(out_word), 32'h1B1B);
        idle();
        hs_w.delete();
        hs_c.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_in_ready_after_drain", 32'(in_ready), 1);
        repeat (2) @(negedge clk);
        chk("t2_handshakes", 32'(hs_w.size()), 2);
        if (hs_w.size() >= 2) begin
            chk("t2_word0", 32'(hs_w[0]), 32'h1B1B);
            chk("t2_word1", 32'(hs_w[1]), 32'hFFFF);
            chk("t2_consecutive", 32'(hs_c[1] - hs_c[0]), 1);
        end

        // 3: early end on beat 4, then a good frame
        send_frame(16'h0000, 4, 4);
        @(negedge clk);
        chk("t3_err_frame", 32'(err_frame), 1);
        chk("t3_err_cnt", 32'(err_cnt), 1);
        chk("t3_out_valid", 32'(out_valid), 0);
        idle();
        @(negedge clk);
        chk("t3_err_pulse_once", 32'(err_frame), 0);
        send_frame(16'hAAAA, 8, 8);
        @(negedge clk);
        chk("t3_out_word", 32'(out_word), 32'hAAAA);
        idle();

        // 4: missing end
        send_frame(16'h5555, 8, 0);
        @(negedge clk);
        chk("t4_err_frame", 32'(err_frame), 1);
        chk("t4_err_cnt", 32'(err_cnt), 2);
        chk("t4_out_valid", 32'(out_valid), 0);
        idle();

        // 5: reset mid-word
        send_frame(16'hC000, 4, 0);
        #3 rst = 1'b0;
        #1;
        chk("t5_in_ready", 32'(in_ready), 0);
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_out_word", 32'(out_word), 0);
        chk("t5_err_cnt", 32'(err_cnt), 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_in_ready_release", 32'(in_ready), 1);
        send_frame(16'hCCCC, 8, 8);
        @(negedge clk);
        chk("t5_out_word", 32'(out_word), 32'hCCCC);
        idle();

        // 6: counter saturation, then LSB-first assembly
        for (int k = 0; k < 300; k++) send(2'd0, 1'b1);
        @(negedge clk);
        chk("t6_err_cnt_sat", 32'(err_cnt), 255);
        chk("t6_model_sat", 32'(m_err_cnt), 255);
        idle();

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            l_in_valid = 1'b1;
            l_in_slice = 2'(i % 4);
            l_in_last  = (i == 7);
        end
        @(negedge clk);
        chk("t6_lsb_out_valid", 32'(l_out_valid), 1);
        chk("t6_lsb_out_word", 32'(l_out_word), 32'hE4E4);
        #1 l_in_valid = 1'b0;
        l_in_last = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
